// File: rtl/char_buf_ctrl_pkg.sv
// char_buf_ctrl_pkg: shared definitions for the character-buffer sequencer.
//   - buffer geometry (64 cells, 6-bit address)
//   - control-code defaults (CC_NL / CC_CLR / CC_BS) and the Null fill code
//   - sequencer state encoding
//   - printable-code classifier and a disjointness check for control codes
package char_buf_ctrl_pkg;

  localparam int BUF_DEPTH = 64;
  localparam int AW        = 6;

  localparam logic [7:0] CHAR_NULL  = 8'h00;
  localparam logic [7:0] CC_NL_DEF  = 8'h0A;
  localparam logic [7:0] CC_CLR_DEF = 8'h0C;
  localparam logic [7:0] CC_BS_DEF  = 8'h08;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  // Printable range of the character encoding: ASCII space..tilde.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  // Control codes must never collide with a printable code or with each other.
  function automatic logic cc_disjoint(input logic [7:0] nl, input logic [7:0] clr,
                                       input logic [7:0] bs);
    return !is_printable(nl) && !is_printable(clr) && !is_printable(bs) &&
           (nl != clr) && (nl != bs) && (clr != bs);
  endfunction

endpackage

// File: rtl/char_buf_ctrl_if.sv
// char_buf_ctrl_if: byte-stream handshake into the sequencer plus the
// single-cell write port towards the character buffer.
//   in_valid/in_ready/in_data : valid/ready byte stream from the text source
//   buf_we/buf_addr/buf_din   : buffer write port (we / wr_addr / din)
// slave  = the sequencer, master = the text source / buffer side.
interface char_buf_ctrl_if;
  import char_buf_ctrl_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_din;

  modport master (
    output in_valid, in_data,
    input  in_ready, buf_we, buf_addr, buf_din
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, buf_we, buf_addr, buf_din
  );

endinterface

// File: rtl/char_fill_seq.sv
// char_fill_seq: range writer. A go pulse loads start/end; from the next cycle
// it presents one write per cycle at start, start+1, ... end (mod 64), then
// drops we. A go while busy restarts it. A single-cell write is simply a
// range with start == end.
//   clk, rst        : clock, synchronous active-high reset
//   go              : load start_addr/end_addr and begin writing
//   start_addr      : first cell
//   end_addr        : last cell (inclusive)
//   addr / we       : registered write address / enable
//   fill_end        : registered copy of the range end
//   done            : the write currently presented is the last of the range
module char_fill_seq
  import char_buf_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] fill_end,
  output logic          we,
  output logic          done
);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      fill_end <= '0;
      we       <= 1'b0;
    end else if (go) begin
      addr     <= start_addr;
      fill_end <= end_addr;
      we       <= 1'b1;
    end else if (we) begin
      if (addr == fill_end) we <= 1'b0;
      else                  addr <= addr + 1'b1;
    end
  end

  assign done = we && (addr == fill_end);

endmodule

// File: rtl/char_buf_ctrl.sv
// char_buf_ctrl: sequencer for the 64-cell character buffer (4 rows of
// ROW_LEN cells, cell 0 top-left). Consumes a byte stream and keeps a write
// cursor; printables become one write, newline pads the rest of the row with
// Null, clear fills all 64 cells with Null.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : char_buf_ctrl_if.slave (in_valid/in_ready/in_data, buf_we/buf_addr/buf_din)
//   clr_req   : external clear pulse, same effect as CC_CLR (wins over a same-cycle byte)
//   busy      : a fill is in progress
//   cursor    : next cell to be written
// Build option: define CHAR_BS_EN to make CC_BS step the cursor back and
// blank that cell; otherwise CC_BS is consumed and ignored.
module char_buf_ctrl
  import char_buf_ctrl_pkg::*;
#(
  parameter int         ROW_LEN = 16,
  parameter logic [7:0] CC_NL   = CC_NL_DEF,
  parameter logic [7:0] CC_CLR  = CC_CLR_DEF,
  parameter logic [7:0] CC_BS   = CC_BS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  char_buf_ctrl_if.slave bus,
  input  logic          clr_req,
  output logic          busy,
  output logic [AW-1:0] cursor
);

  if (!cc_disjoint(CC_NL, CC_CLR, CC_BS) || (ROW_LEN < 1) || (ROW_LEN > BUF_DEPTH) ||
      ((ROW_LEN & (ROW_LEN - 1)) != 0)) begin : g_bad_cfg
    $error("char_buf_ctrl: control codes overlap printables/each other or ROW_LEN invalid");
  end

  localparam logic [AW-1:0] COL_MASK = AW'(ROW_LEN - 1);
  localparam logic [AW-1:0] LAST     = AW'(BUF_DEPTH - 1);

  state_e        state;
  logic          fill_clr;   // current fill is a full clear (cursor -> 0 at the end)
  logic [7:0]    din_r;
  logic          accept;
  logic          clr_now;    // clear request taken this cycle from IDLE
  logic [AW-1:0] row_end;
  logic          go;
  logic [AW-1:0] go_start, go_end;
  logic [AW-1:0] fill_end;
  logic          fill_done;

  assign bus.in_ready = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign clr_now      = clr_req || (accept && bus.in_data == CC_CLR);
  assign row_end      = cursor | COL_MASK;

  // Decode what the range writer must do this cycle.
  always_comb begin
    go       = 1'b0;
    go_start = cursor;
    go_end   = cursor;
    if (state == ST_IDLE) begin
      if (clr_now) begin
        go       = 1'b1;
        go_start = '0;
        go_end   = LAST;
      end else if (accept) begin
        if (bus.in_data == CC_NL) begin
          go     = 1'b1;
          go_end = row_end;
        end
`ifdef CHAR_BS_EN
        else if (bus.in_data == CC_BS) begin
          go       = 1'b1;
          go_start = cursor - 1'b1;
          go_end   = cursor - 1'b1;
        end
`endif
        else if (bus.in_data != CC_BS && is_printable(bus.in_data)) begin
          go = 1'b1;
        end
      end
    end else if (clr_req && !fill_clr) begin
      // newline fill aborted: restart as a full clear from cell 0
      go       = 1'b1;
      go_start = '0;
      go_end   = LAST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cursor   <= '0;
      fill_clr <= 1'b0;
      din_r    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_now) begin
            state    <= ST_FILL;
            fill_clr <= 1'b1;
            din_r    <= CHAR_NULL;
          end else if (accept) begin
            if (bus.in_data == CC_NL) begin
              state    <= ST_FILL;
              fill_clr <= 1'b0;
              din_r    <= CHAR_NULL;
            end
`ifdef CHAR_BS_EN
            else if (bus.in_data == CC_BS) begin
              cursor <= cursor - 1'b1;
              din_r  <= CHAR_NULL;
            end
`endif
            else if (bus.in_data != CC_BS && is_printable(bus.in_data)) begin
              cursor <= cursor + 1'b1;
              din_r  <= bus.in_data;
            end
          end
        end
        ST_FILL: begin
          if (clr_req && !fill_clr) begin
            fill_clr <= 1'b1;
          end else if (fill_done) begin
            state  <= ST_IDLE;
            cursor <= fill_clr ? '0 : fill_end + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  char_fill_seq u_fill (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .start_addr (go_start),
    .end_addr   (go_end),
    .addr       (bus.buf_addr),
    .fill_end   (fill_end),
    .we         (bus.buf_we),
    .done       (fill_done)
  );

  assign bus.buf_din = din_r;

endmodule

// File: tb/tb_char_buf_ctrl.sv
// Scoreboard bench for char_buf_ctrl: stimulus pushes the expected buffer
// writes into a queue from a cell-level model; a monitor pops one entry per
// observed write.
module tb_char_buf_ctrl;
  import char_buf_ctrl_pkg::*;

`ifdef CHAR_BS_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  typedef struct {
    int addr;
    int din;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_req;
  logic       busy;
  logic [5:0] cursor;

  char_buf_ctrl_if bus();

  char_buf_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .clr_req (clr_req),
    .busy    (busy),
    .cursor  (cursor)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  mcur     = 0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic void push_wr(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.din  = d;
    exp_q.push_back(w);
  endfunction

  function automatic void push_clear();
    for (int a = 0; a < 64; a++) push_wr(a, 0);
    mcur = 0;
  endfunction

  // Effect of one accepted byte on the buffer, from the cell-level rules.
  function automatic void model_accept(input logic [7:0] b);
    int re;
    if (b == CC_CLR_DEF) begin
      push_clear();
    end else if (b == CC_NL_DEF) begin
      re = (mcur / 16) * 16 + 15;
      for (int a = mcur; a <= re; a++) push_wr(a, 0);
      mcur = (re + 1) % 64;
    end else if (b == CC_BS_DEF) begin
      if (BS_EN) begin
        mcur = (mcur + 63) % 64;
        push_wr(mcur, 0);
      end
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(mcur, int'(b));
      mcur = (mcur + 1) % 64;
    end
  endfunction

  // Monitor: every observed write must be the next expected one.
  wr_t mon_w;
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.buf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=addr %0d din %0d required=no write",
                 bus.buf_addr, bus.buf_din);
      end else begin
        mon_w = exp_q.pop_front();
        chk("wr_addr", int'(bus.buf_addr), mon_w.addr);
        chk("wr_din", int'(bus.buf_din), mon_w.din);
      end
    end
  end

  // Wait (bounded) at a negedge until the block is ready.
  task automatic wait_ready(output bit ok);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.in_ready === 1'b1);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=%0d required=1", bus.in_ready);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    wait_ready(ok);
    if (ok) begin
      chk("cursor", int'(cursor), mcur);
      model_accept(b);
      @(posedge clk);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic clr_pulse(input bit with_byte, input logic [7:0] b);
    bit ok;
    @(negedge clk);
    wait_ready(ok);
    if (ok) begin
      chk("cursor", int'(cursor), mcur);
      clr_req      = 1'b1;
      bus.in_valid = with_byte;
      bus.in_data  = b;
      push_clear();
      @(posedge clk);
    end
    #1;
    clr_req      = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.in_ready !== 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_cursor", int'(cursor), mcur);
  endtask

  task automatic count_low(output int n);
    n = 0;
    @(negedge clk);
    while (bus.in_ready === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  int  cnt;
  int  r;
  bit  ok;

  initial begin
    rst          = 1'b1;
    clr_req      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_we", int'(bus.buf_we), 0);
    chk("rst_cursor", int'(cursor), 0);
    chk("rst_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(busy), 0);

    // 1: back-to-back printables
    send("H");
    send("i");
    drain();
    chk("t1_cursor", int'(cursor), 2);

    // 2: newline from column 5
    send("a"); send("b"); send("c");
    send(CC_NL_DEF);
    count_low(cnt);
    chk("t2_ready_low", cnt, 11);
    drain();
    chk("t2_cursor", int'(cursor), 16);

    // 3: wrap 63 -> 0, then newline from 0
    send(CC_NL_DEF);
    send(CC_NL_DEF);
    for (int i = 0; i < 15; i++) send(8'(8'h41 + i));
    drain();
    chk("t3_cursor63", int'(cursor), 63);
    send("A");
    drain();
    chk("t3_cursor0", int'(cursor), 0);
    send(CC_NL_DEF);
    drain();
    chk("t3_cursor16", int'(cursor), 16);

    // 4: clr_req with a byte in the same cycle
    clr_pulse(1'b1, "X");
    cnt = 0;
    @(negedge clk);
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("t4_busy_cycles", cnt, 64);
    drain();
    chk("t4_cursor", int'(cursor), 0);

    // 5: newline at 32 aborted by clr_req on the 3rd fill cycle
    send(CC_NL_DEF);
    send(CC_NL_DEF);
    drain();
    chk("t5_cursor32", int'(cursor), 32);
    @(negedge clk);
    wait_ready(ok);
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.in_data  = CC_NL_DEF;
      chk("cursor", int'(cursor), mcur);
      push_wr(32, 0); push_wr(33, 0); push_wr(34, 0);
      push_clear();
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 clr_req = 1'b1;
      @(posedge clk);
      #1 clr_req = 1'b0;
    end
    drain();
    chk("t5_cursor", int'(cursor), 0);

    // 6: backspace at cursor 0
    send(CC_BS_DEF);
    drain();
    chk("t6_cursor", int'(cursor), BS_EN ? 63 : 0);

    // Unknown control code is dropped
    send(8'h1B);
    drain();

    // Mid-fill reset abandons the fill
    clr_pulse(1'b0, 8'h00);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    mcur = 0;
    @(posedge clk);
    #1;
    chk("rst_abort_we", int'(bus.buf_we), 0);
    rst = 1'b0;
    drain();

    // Randomized traffic
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      send(8'($urandom_range(8'h20, 8'h7E)));
      else if (r < 72) send(CC_NL_DEF);
      else if (r < 75) send(CC_CLR_DEF);
      else if (r < 82) send(CC_BS_DEF);
      else if (r < 85) send(8'h1B);
      else if (r < 88) clr_pulse(1'($urandom_range(0, 1)), 8'($urandom_range(8'h20, 8'h7E)));
      else             repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
